// File: rtl/sudoku_stats.sv
// Per-puzzle latency/outcome monitor for the sudoku solver, with watchdog abort.
// Optional latency history FIFO enabled by defining SUDOKU_STATS_HIST_EN.
module sudoku_stats #(
  parameter int CYC_W   = 32,
  parameter int CNT_W   = 10,
  parameter int TIMEOUT = 100000,
  parameter int HIST_D  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             next_puzzle,
  input  logic             solution,
  input  logic             give_up,
  input  logic             match_valid,
  input  logic             match,
  output logic             timeout,
  output logic             busy,
  output logic [CYC_W-1:0] last_cycles,
  output logic [CYC_W-1:0] min_cycles,
  output logic [CYC_W-1:0] max_cycles,
  output logic [CYC_W-1:0] total_cycles,
  output logic [CNT_W-1:0] num_correct,
  output logic [CNT_W-1:0] num_wrong,
  output logic [CNT_W-1:0] num_gave_up,
  output logic [CNT_W-1:0] num_timeout,
  input  logic             hist_rd,
  output logic [CYC_W-1:0] hist_data,
  output logic             hist_empty,
  output logic             hist_ovf
);

  typedef enum logic [1:0] {IDLE, RUN, WAIT} state_t;

  localparam logic [CYC_W-1:0] PC_LAST = CYC_W'(TIMEOUT - 1);

  state_t           state, state_next;
  logic [CYC_W-1:0] pc;
  logic [CYC_W-1:0] lat;
  logic             pending;
  logic             pc_hit;
  logic             ev_solve, ev_give, ev_tout, ev_end, ev_verdict;
  logic [CYC_W:0]   total_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // An end strobe seen while pc holds N-1 means the puzzle took N cycles.
  assign lat       = pc + CYC_W'(1);
  assign pc_hit    = (pc == PC_LAST);
  assign total_sum = {1'b0, total_cycles} + {1'b0, lat};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (next_puzzle) state_next = RUN;
      RUN: begin
        if (solution)         state_next = WAIT;
        else if (give_up)     state_next = IDLE;
        else if (next_puzzle) state_next = RUN;
        else if (pc_hit)      state_next = IDLE;
      end
      WAIT: if (match_valid) state_next = (pending || next_puzzle) ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ev_solve   = (state == RUN) && solution;
    ev_give    = (state == RUN) && !solution && (give_up || next_puzzle);
    ev_tout    = (state == RUN) && !solution && !give_up && !next_puzzle && pc_hit;
    ev_end     = ev_solve || ev_give || ev_tout;
    ev_verdict = (state == WAIT) && match_valid;
    busy       = (state != IDLE);
  end

  // pc restarts on every entry into RUN, including a restart from RUN itself.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= '0;
      pending <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= ev_tout;
      if (state_next == RUN && (state != RUN || ev_give)) pc <= '0;
      else if (state == RUN)                              pc <= pc + CYC_W'(1);
      if (state == WAIT) begin
        if (match_valid)      pending <= 1'b0;
        else if (next_puzzle) pending <= 1'b1;
      end else begin
        pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_cycles  <= '0;
      min_cycles   <= '1;
      max_cycles   <= '0;
      total_cycles <= '0;
      num_correct  <= '0;
      num_wrong    <= '0;
      num_gave_up  <= '0;
      num_timeout  <= '0;
    end else begin
      if (ev_end) begin
        last_cycles  <= lat;
        total_cycles <= total_sum[CYC_W] ? '1 : total_sum[CYC_W-1:0];
      end
      if (ev_solve) begin
        if (lat < min_cycles) min_cycles <= lat;
        if (lat > max_cycles) max_cycles <= lat;
      end
      if (ev_give) num_gave_up <= sat_inc(num_gave_up);
      if (ev_tout) num_timeout <= sat_inc(num_timeout);
      if (ev_verdict) begin
        if (match) num_correct <= sat_inc(num_correct);
        else       num_wrong   <= sat_inc(num_wrong);
      end
    end
  end

`ifdef SUDOKU_STATS_HIST_EN
  localparam int             AW       = (HIST_D > 1) ? $clog2(HIST_D) : 1;
  localparam logic [AW:0]    FULL_CNT = HIST_D[AW:0];

  logic [CYC_W-1:0] mem [HIST_D];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, pop, push;

  assign full       = (count == FULL_CNT);
  assign hist_empty = (count == '0);
  assign pop        = hist_rd && !hist_empty;
  // A pop frees a slot in the same cycle, so a full FIFO still accepts the push.
  assign push       = ev_solve && (!full || pop);
  assign hist_data  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= lat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      hist_ovf <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (ev_solve && full && !pop) hist_ovf <= 1'b1;
    end
  end
`else
  logic unused_hist;
  assign unused_hist = hist_rd ^ (HIST_D == 0);
  assign hist_data   = '0;
  assign hist_empty  = 1'b1;
  assign hist_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_sudoku_stats.sv
// Directed self-checking bench for sudoku_stats (TIMEOUT=16, CNT_W=3, HIST_D=4).
// History checks follow SUDOKU_STATS_HIST_EN when it is defined for the build.
module tb_sudoku_stats;
  localparam int CYC_W = 32, CNT_W = 3, TIMEOUT = 16, HIST_D = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic next_puzzle = 0, solution = 0, give_up = 0, match_valid = 0, match = 0, hist_rd = 0;
  logic timeout, busy, hist_empty, hist_ovf;
  logic [CYC_W-1:0] last_cycles, min_cycles, max_cycles, total_cycles, hist_data;
  logic [CNT_W-1:0] num_correct, num_wrong, num_gave_up, num_timeout;
  int checks = 0, errors = 0;

  sudoku_stats #(.CYC_W(CYC_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .HIST_D(HIST_D)) dut (
    .clk(clk), .rst(rst), .next_puzzle(next_puzzle), .solution(solution), .give_up(give_up),
    .match_valid(match_valid), .match(match), .timeout(timeout), .busy(busy),
    .last_cycles(last_cycles), .min_cycles(min_cycles), .max_cycles(max_cycles),
    .total_cycles(total_cycles), .num_correct(num_correct), .num_wrong(num_wrong),
    .num_gave_up(num_gave_up), .num_timeout(num_timeout), .hist_rd(hist_rd),
    .hist_data(hist_data), .hist_empty(hist_empty), .hist_ovf(hist_ovf));

  always #5 clk = ~clk;

  // Inputs change on negedge, DUT samples on posedge, outputs are read on negedge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    {next_puzzle, solution, give_up, match_valid, match, hist_rd} = '0;
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(1);
  endtask

  task automatic do_next();
    next_puzzle = 1'b1; idle(1); next_puzzle = 1'b0;
  endtask

  task automatic do_solution();
    solution = 1'b1; idle(1); solution = 1'b0;
  endtask

  task automatic do_give_up();
    give_up = 1'b1; idle(1); give_up = 1'b0;
  endtask

  task automatic do_verdict(input logic m);
    match_valid = 1'b1; match = m; idle(1); match_valid = 1'b0; match = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_busy got=%0d exp=0", busy); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL rst_timeout got=%0d exp=0", timeout); end
    checks++; if (last_cycles !== 0) begin errors++; $display("[TB] FAIL rst_last got=%0d exp=0", last_cycles); end
    checks++; if (min_cycles !== '1) begin errors++; $display("[TB] FAIL rst_min got=%0h exp=ffffffff", min_cycles); end
    checks++; if (max_cycles !== 0) begin errors++; $display("[TB] FAIL rst_max got=%0d exp=0", max_cycles); end
    checks++; if (total_cycles !== 0) begin errors++; $display("[TB] FAIL rst_total got=%0d exp=0", total_cycles); end
    checks++; if ({num_correct, num_wrong, num_gave_up, num_timeout} !== '0) begin errors++;
      $display("[TB] FAIL rst_counters got=%0d/%0d/%0d/%0d exp=0/0/0/0", num_correct, num_wrong, num_gave_up, num_timeout); end
    checks++; if (hist_empty !== 1'b1 || hist_ovf !== 1'b0) begin errors++;
      $display("[TB] FAIL rst_hist got empty=%0d ovf=%0d exp empty=1 ovf=0", hist_empty, hist_ovf); end
  endtask

  task automatic test_single_solve();
    do_reset();
    do_next(); idle(9); do_solution();
    checks++; if (last_cycles !== 10) begin errors++; $display("[TB] FAIL t1_last got=%0d exp=10", last_cycles); end
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL t1_busy_wait got=%0d exp=1", busy); end
    idle(1); do_verdict(1'b1);
    checks++; if (min_cycles !== 10 || max_cycles !== 10) begin errors++;
      $display("[TB] FAIL t1_minmax got=%0d/%0d exp=10/10", min_cycles, max_cycles); end
    checks++; if (total_cycles !== 10) begin errors++; $display("[TB] FAIL t1_total got=%0d exp=10", total_cycles); end
    checks++; if (num_correct !== 3'd1) begin errors++; $display("[TB] FAIL t1_correct got=%0d exp=1", num_correct); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL t1_busy_idle got=%0d exp=0", busy); end
  endtask

  task automatic test_min_max();
    do_reset();
    do_next(); idle(9); do_solution(); do_verdict(1'b1);
    do_next(); idle(3); do_solution(); do_verdict(1'b0);
    checks++; if (min_cycles !== 4) begin errors++; $display("[TB] FAIL t2_min got=%0d exp=4", min_cycles); end
    checks++; if (max_cycles !== 10) begin errors++; $display("[TB] FAIL t2_max got=%0d exp=10", max_cycles); end
    checks++; if (total_cycles !== 14) begin errors++; $display("[TB] FAIL t2_total got=%0d exp=14", total_cycles); end
    checks++; if (num_wrong !== 3'd1 || num_correct !== 3'd1) begin errors++;
      $display("[TB] FAIL t2_verdicts got=%0d/%0d exp=1/1", num_correct, num_wrong); end
  endtask

  task automatic test_timeout();
    int found = 0;
    do_reset();
    do_next();
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (timeout === 1'b1) begin found = i; break; end
    end
    checks++; if (found != TIMEOUT) begin errors++; $display("[TB] FAIL t3_timeout_cycle got=%0d exp=%0d", found, TIMEOUT); end
    checks++; if (last_cycles !== TIMEOUT) begin errors++; $display("[TB] FAIL t3_last got=%0d exp=%0d", last_cycles, TIMEOUT); end
    checks++; if (num_timeout !== 3'd1) begin errors++; $display("[TB] FAIL t3_num_timeout got=%0d exp=1", num_timeout); end
    checks++; if (min_cycles !== '1 || max_cycles !== 0) begin errors++;
      $display("[TB] FAIL t3_minmax got=%0h/%0d exp=ffffffff/0", min_cycles, max_cycles); end
    checks++; if (total_cycles !== TIMEOUT || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL t3_total_busy got=%0d/%0d exp=%0d/0", total_cycles, busy, TIMEOUT); end
    idle(1);
    checks++; if (timeout !== 1'b0) begin errors++; $display("[TB] FAIL t3_pulse_width got=%0d exp=0", timeout); end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    do_next(); idle(TIMEOUT - 1); do_solution();
    checks++; if (timeout !== 1'b0 || busy !== 1'b1) begin errors++;
      $display("[TB] FAIL bnd_solve_state got timeout=%0d busy=%0d exp 0/1", timeout, busy); end
    checks++; if (last_cycles !== TIMEOUT) begin errors++; $display("[TB] FAIL bnd_solve_last got=%0d exp=%0d", last_cycles, TIMEOUT); end
    do_verdict(1'b0);
    checks++; if (num_wrong !== 3'd1) begin errors++; $display("[TB] FAIL bnd_wrong got=%0d exp=1", num_wrong); end
    do_next(); idle(TIMEOUT - 1); do_give_up();
    checks++; if (timeout !== 1'b0 || num_timeout !== 3'd0) begin errors++;
      $display("[TB] FAIL bnd_giveup_timeout got=%0d/%0d exp=0/0", timeout, num_timeout); end
    checks++; if (num_gave_up !== 3'd1 || busy !== 1'b0) begin errors++;
      $display("[TB] FAIL bnd_giveup got=%0d busy=%0d exp=1/0", num_gave_up, busy); end
  endtask

  task automatic test_pending();
    do_reset();
    do_next(); idle(4);
    solution = 1'b1; give_up = 1'b1; idle(1); solution = 1'b0; give_up = 1'b0;
    checks++; if (busy !== 1'b1 || num_gave_up !== 3'd0) begin errors++;
      $display("[TB] FAIL t4_solve_wins got busy=%0d gave_up=%0d exp 1/0", busy, num_gave_up); end
    checks++; if (last_cycles !== 5) begin errors++; $display("[TB] FAIL t4_last got=%0d exp=5", last_cycles); end
    do_next(); do_verdict(1'b1);
    checks++; if (busy !== 1'b1 || num_correct !== 3'd1) begin errors++;
      $display("[TB] FAIL t4_pending_run got busy=%0d correct=%0d exp 1/1", busy, num_correct); end
    idle(2); do_give_up();
    checks++; if (last_cycles !== 3 || num_gave_up !== 3'd1) begin errors++;
      $display("[TB] FAIL t4_second got last=%0d gave_up=%0d exp 3/1", last_cycles, num_gave_up); end
    checks++; if (total_cycles !== 8 || min_cycles !== 5 || max_cycles !== 5) begin errors++;
      $display("[TB] FAIL t4_stats got total=%0d min=%0d max=%0d exp 8/5/5", total_cycles, min_cycles, max_cycles); end
  endtask

  task automatic test_restart();
    do_reset();
    do_next(); idle(2); do_next();
    checks++; if (last_cycles !== 3 || num_gave_up !== 3'd1 || busy !== 1'b1) begin errors++;
      $display("[TB] FAIL rs_restart got last=%0d gave_up=%0d busy=%0d exp 3/1/1", last_cycles, num_gave_up, busy); end
    idle(1); do_solution();
    checks++; if (last_cycles !== 2 || min_cycles !== 2 || total_cycles !== 5) begin errors++;
      $display("[TB] FAIL rs_solve got last=%0d min=%0d total=%0d exp 2/2/5", last_cycles, min_cycles, total_cycles); end
    do_verdict(1'b1);
  endtask

  task automatic test_saturation();
    do_reset();
    do_next();
    repeat (9) do_next();
    do_give_up();
    checks++; if (num_gave_up !== 3'd7) begin errors++; $display("[TB] FAIL sat_gave_up got=%0d exp=7", num_gave_up); end
    checks++; if (total_cycles !== 10) begin errors++; $display("[TB] FAIL sat_total got=%0d exp=10", total_cycles); end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    do_reset();
    do_next(); idle(2); do_solution(); do_verdict(1'b1);
    do_next(); idle(5);
    rst = 1'b1; #1;
    checks++; if (busy !== 1'b0 || timeout !== 1'b0) begin errors++;
      $display("[TB] FAIL t5_state got busy=%0d timeout=%0d exp 0/0", busy, timeout); end
    checks++; if (last_cycles !== 0 || total_cycles !== 0 || min_cycles !== '1 || max_cycles !== 0) begin errors++;
      $display("[TB] FAIL t5_lat got %0d/%0d/%0h/%0d exp 0/0/ffffffff/0", last_cycles, total_cycles, min_cycles, max_cycles); end
    checks++; if (num_correct !== 3'd0) begin errors++; $display("[TB] FAIL t5_correct got=%0d exp=0", num_correct); end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 2 * TIMEOUT; i++) begin
      @(negedge clk);
      if (timeout !== 1'b0 || busy !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("[TB] FAIL t5_quiet got=%0d active cycles exp=0", seen); end
  endtask

  task automatic test_history();
    do_reset();
`ifdef SUDOKU_STATS_HIST_EN
    for (int l = 3; l <= 7; l++) begin
      do_next(); idle(l - 1); do_solution(); do_verdict(1'b1);
    end
    checks++; if (hist_ovf !== 1'b1 || hist_empty !== 1'b0) begin errors++;
      $display("[TB] FAIL t6_ovf got ovf=%0d empty=%0d exp 1/0", hist_ovf, hist_empty); end
    for (int i = 0; i < HIST_D; i++) begin
      checks++; if (hist_data !== 32'(3 + i)) begin errors++;
        $display("[TB] FAIL t6_pop%0d got=%0d exp=%0d", i, hist_data, 3 + i); end
      hist_rd = 1'b1; idle(1); hist_rd = 1'b0;
    end
    checks++; if (hist_empty !== 1'b1 || hist_ovf !== 1'b1) begin errors++;
      $display("[TB] FAIL t6_drained got empty=%0d ovf=%0d exp 1/1", hist_empty, hist_ovf); end
`else
    do_next(); idle(3); do_solution(); do_verdict(1'b1);
    hist_rd = 1'b1; idle(1); hist_rd = 1'b0;
    checks++; if (hist_empty !== 1'b1 || hist_ovf !== 1'b0 || hist_data !== 0) begin errors++;
      $display("[TB] FAIL nohist got empty=%0d ovf=%0d data=%0d exp 1/0/0", hist_empty, hist_ovf, hist_data); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_solve();
    test_min_max();
    test_timeout();
    test_timeout_boundary();
    test_pending();
    test_restart();
    test_saturation();
    test_reset_mid_run();
    test_history();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
